master_in: RTL and testbench
============================

Name: master_in

Overview:
- Master-side receive path of the serial system bus.
- On a read instruction it raises master_ready and waits for the slave's slave_valid.
- It then deserialises 8-bit bytes from the one-bit rx_data line, MSB first.
- It presents each byte on data with a one-cycle new_rx strobe, and flags rx_done after the last byte of a single or burst read.

Parameters:
- DATA_WIDTH, 8: bits per transferred byte.
- BURST_WIDTH, 12: width of burst_num and of the internal byte counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- slave_valid  input  1  slave is driving read data on rx_data.
- rx_data  input  1  serial read data, one bit per clock, MSB first.
- burst_num  input  BURST_WIDTH  bytes in the read; 0 or 1 means single byte.
- instruction  input  2  2'b11 = read request; any other value = no read.
- rx_done  output  1  read transaction complete.
- master_ready  output  1  master is ready to accept read data.
- new_rx  output  1  one-cycle strobe: data holds a freshly received byte.
- data  output  DATA_WIDTH  last completed received byte.

Behaviour:
- One clock domain (clk). reset is asynchronous and active-high.
- Reset forces state IDLE and clears every output: rx_done=0, master_ready=0, new_rx=0, data=0. It also clears the shift register, bit counter and byte counter. Reset mid-transfer discards the partial byte.
- All outputs are registered.
- States: IDLE, WAIT_VALID, RECEIVE, BYTE_GAP, DONE.
- IDLE:
  - When instruction==2'b11, latch the byte total = (burst_num==0 ? 1 : burst_num) and go to WAIT_VALID.
  - master_ready rises in the same edge.
- WAIT_VALID:
  - master_ready=1.
  - At an edge with slave_valid=1, go to RECEIVE with bit counter 0. No bit is sampled on this edge.
- RECEIVE:
  - Each edge shifts rx_data into the shift register LSB, so the first bit received ends up as data[7].
  - The bit counter increments per edge.
  - On the 8th sampling edge:
    - data is loaded with the complete byte and new_rx=1 for exactly one cycle.
    - The byte counter increments.
    - If that byte was the last, go to DONE; otherwise go to BYTE_GAP.
- BYTE_GAP:
  - Exactly one idle cycle; rx_data is ignored.
  - Return to RECEIVE with bit counter 0. The next byte's first bit is sampled on the following edge.
- DONE:
  - rx_done=1 and master_ready=0; data holds the last byte.
  - Remain in DONE until instruction!=2'b11 (then go to IDLE and clear rx_done) or reset.
- Aborts:
  - slave_valid=0 during RECEIVE or BYTE_GAP abandons the partial byte (no new_rx) and returns to WAIT_VALID. Already-received byte count is kept.
  - instruction!=2'b11 in any state other than IDLE returns to IDLE. master_ready, rx_done and new_rx are cleared; data is kept.
- new_rx and rx_done rise on the same edge for the final byte.
- burst_num is sampled only on the IDLE→WAIT_VALID edge; later changes have no effect.
- Maximum burst is 2^BURST_WIDTH-1 = 4095 bytes; the counter never wraps within a transaction.

Optional Feature:
- MASTER_IN_LSB_FIRST_EN defined: bits are received LSB first. The first sampled bit lands in data[0] (shift right, rx_data into MSB).
- Undefined (default): MSB-first reception as specified above.
- Timing, handshake and state machine are identical in both builds.

Test Plan:
- Reset: assert reset mid-cycle → all outputs 0 immediately (asynchronous), state IDLE; release → stays IDLE with instruction=2'b00.
- Single read: instruction=2'b11, burst_num=0 → master_ready=1 next edge. Raise slave_valid, then bits 0,1,1,0,1,0,1,1 on consecutive cycles → data=8'h6B, new_rx one cycle, rx_done=1, master_ready=0 on the 8th sampling edge.
- Burst read: burst_num=3, slave_valid=1, bytes 0x7A, 0x2B, 0x7B with one gap cycle between bytes → three new_rx pulses 9 cycles apart with data 0x7A, 0x2B, 0x7B. rx_done rises only with the third pulse.
- Reset mid-burst: assert reset after byte 1 plus 4 bits → outputs clear. A new single read afterwards returns the correct byte.
- Abort: drop slave_valid after 5 bits → no new_rx, return to WAIT_VALID with master_ready=1. A full byte later yields a correct new_rx.
- Release: after rx_done, set instruction=2'b00 → rx_done falls next edge; the data value persists.

Source files
------------

// File: rtl/master_in.sv
// ============================================================================
// master_in : serial-bus master receive path (read deserialiser + handshake)
// Optional: define MASTER_IN_LSB_FIRST_EN for LSB-first bit order.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module master_in #(
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   slave_valid,
  input  logic                   rx_data,
  input  logic [BURST_WIDTH-1:0] burst_num,
  input  logic [1:0]             instruction,
  output logic                   rx_done,
  output logic                   master_ready,
  output logic                   new_rx,
  output logic [DATA_WIDTH-1:0]  data
);

  localparam int          CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [1:0]  C_RD_INS = 2'b11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_VALID = 3'd1,
    RECEIVE    = 3'd2,
    BYTE_GAP   = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [BURST_WIDTH-1:0] r_byte_cnt;
  logic [BURST_WIDTH-1:0] r_total;

  logic                   w_read;
  logic [DATA_WIDTH-1:0]  w_shift_next;
  logic [BURST_WIDTH-1:0] w_byte_cnt_next;
  logic [BURST_WIDTH-1:0] w_total;
  logic                   w_last_bit;

  assign w_read = (instruction == C_RD_INS);

`ifdef MASTER_IN_LSB_FIRST_EN
  assign w_shift_next = {rx_data, r_shift[DATA_WIDTH-1:1]};
`else
  assign w_shift_next = {r_shift[DATA_WIDTH-2:0], rx_data};
`endif

  assign w_byte_cnt_next = r_byte_cnt + 1'b1;
  // A burst_num of zero is treated as a single-byte read.
  assign w_total    = (burst_num == '0) ? BURST_WIDTH'(1) : burst_num;
  assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_total      <= '0;
      rx_done      <= 1'b0;
      master_ready <= 1'b0;
      new_rx       <= 1'b0;
      data         <= '0;
    end else begin
      new_rx <= 1'b0;
      if (r_state != IDLE && !w_read) begin
        r_state      <= IDLE;
        master_ready <= 1'b0;
        rx_done      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_read) begin
              r_total      <= w_total;
              r_byte_cnt   <= '0;
              master_ready <= 1'b1;
              r_state      <= WAIT_VALID;
            end
          end
          WAIT_VALID: begin
            master_ready <= 1'b1;
            if (slave_valid) begin
              r_bit_cnt <= '0;
              r_state   <= RECEIVE;
            end
          end
          RECEIVE: begin
            if (!slave_valid) begin
              r_bit_cnt <= '0;
              r_state   <= WAIT_VALID;
            end else begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_last_bit) begin
                data       <= w_shift_next;
                new_rx     <= 1'b1;
                r_byte_cnt <= w_byte_cnt_next;
                if (w_byte_cnt_next >= r_total) begin
                  rx_done      <= 1'b1;
                  master_ready <= 1'b0;
                  r_state      <= DONE;
                end else begin
                  r_state <= BYTE_GAP;
                end
              end
            end
          end
          BYTE_GAP: begin
            r_bit_cnt <= '0;
            r_state   <= slave_valid ? RECEIVE : WAIT_VALID;
          end
          DONE: begin
            rx_done      <= 1'b1;
            master_ready <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_master_in.sv
// Directed self-checking bench for master_in (serial read receive path).
`default_nettype none

module tb_master_in;

  logic        clk = 1'b0;
  logic        reset;
  logic        slave_valid;
  logic        rx_data;
  logic [11:0] burst_num;
  logic [1:0]  instruction;
  logic        rx_done;
  logic        master_ready;
  logic        new_rx;
  logic [7:0]  data;

  int n_checks = 0;
  int n_fail   = 0;

  master_in #(.DATA_WIDTH(8), .BURST_WIDTH(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .slave_valid  (slave_valid),
    .rx_data      (rx_data),
    .burst_num    (burst_num),
    .instruction  (instruction),
    .rx_done      (rx_done),
    .master_ready (master_ready),
    .new_rx       (new_rx),
    .data         (data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one byte in wire order; checks new_rx stays low until the last bit.
  task automatic send_byte(input logic [7:0] b, input string name);
    for (int k = 0; k < 8; k++) begin
`ifdef MASTER_IN_LSB_FIRST_EN
      rx_data = b[k];
`else
      rx_data = b[7-k];
`endif
      tick();
      if (k < 7) begin
        n_checks++;
        if (new_rx !== 1'b0) begin
          n_fail++;
          $display("FAIL %s early_new_rx bit=%0d got=%b want=0", name, k, new_rx);
        end
      end
    end
  endtask

  task automatic test_reset();
    instruction = 2'b11; burst_num = 12'd0;
    tick();
    n_checks++;
    if (master_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_ready got=%b want=1", master_ready);
    end
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({rx_done, master_ready, new_rx, data} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_async got rd=%b mr=%b nr=%b d=%h want all 0",
               rx_done, master_ready, new_rx, data);
    end
    instruction = 2'b00;
    tick();
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if ({rx_done, master_ready, new_rx, data} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_idle got rd=%b mr=%b nr=%b d=%h want all 0",
               rx_done, master_ready, new_rx, data);
    end
  endtask

  task automatic test_single();
    instruction = 2'b11; burst_num = 12'd0;
    tick();
    n_checks++;
    if (master_ready !== 1'b1 || rx_done !== 1'b0) begin
      n_fail++; $display("FAIL single_ready got mr=%b rd=%b want 1/0", master_ready, rx_done);
    end
    slave_valid = 1'b1;
    tick();
    n_checks++;
    if (new_rx !== 1'b0) begin
      n_fail++; $display("FAIL single_valid_edge new_rx got=%b want=0", new_rx);
    end
    send_byte(8'h6B, "single");
    n_checks++;
    if (data !== 8'h6B || new_rx !== 1'b1 || rx_done !== 1'b1 || master_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_byte got d=%h nr=%b rd=%b mr=%b want 6b/1/1/0",
               data, new_rx, rx_done, master_ready);
    end
    tick();
    n_checks++;
    if (new_rx !== 1'b0 || rx_done !== 1'b1) begin
      n_fail++; $display("FAIL single_strobe_len got nr=%b rd=%b want 0/1", new_rx, rx_done);
    end
  endtask

  task automatic test_release();
    instruction = 2'b00; slave_valid = 1'b0;
    tick();
    n_checks++;
    if (rx_done !== 1'b0 || data !== 8'h6B || master_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL release got rd=%b d=%h mr=%b want 0/6b/0", rx_done, data, master_ready);
    end
  endtask

  task automatic test_burst();
    logic [7:0] bytes [3];
    bytes[0] = 8'h7A; bytes[1] = 8'h2B; bytes[2] = 8'h7B;
    instruction = 2'b11; burst_num = 12'd3;
    tick();
    burst_num = 12'd1;  // latched total must be unaffected
    slave_valid = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      send_byte(bytes[j], "burst");
      n_checks++;
      if (new_rx !== 1'b1 || data !== bytes[j] || rx_done !== (j == 2)) begin
        n_fail++;
        $display("FAIL burst_byte%0d got nr=%b d=%h rd=%b want 1/%h/%b",
                 j, new_rx, data, rx_done, bytes[j], (j == 2));
      end
      if (j < 2) begin
        rx_data = ~bytes[j+1][7];  // ignored during the gap
        tick();
        n_checks++;
        if (new_rx !== 1'b0 || rx_done !== 1'b0 || master_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL burst_gap%0d got nr=%b rd=%b mr=%b want 0/0/1",
                   j, new_rx, rx_done, master_ready);
        end
      end
    end
    instruction = 2'b00; slave_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    instruction = 2'b11; burst_num = 12'd2;
    tick();
    slave_valid = 1'b1;
    tick();
    send_byte(8'h3C, "midrst");
    n_checks++;
    if (new_rx !== 1'b1 || data !== 8'h3C) begin
      n_fail++; $display("FAIL midrst_first got nr=%b d=%h want 1/3c", new_rx, data);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      rx_data = k[0];
      tick();
    end
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({rx_done, master_ready, new_rx, data} !== 11'd0) begin
      n_fail++;
      $display("FAIL midrst_clear got rd=%b mr=%b nr=%b d=%h want all 0",
               rx_done, master_ready, new_rx, data);
    end
    instruction = 2'b00; slave_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    instruction = 2'b11; burst_num = 12'd1;
    tick();
    slave_valid = 1'b1;
    tick();
    send_byte(8'hC5, "midrst_new");
    n_checks++;
    if (data !== 8'hC5 || new_rx !== 1'b1 || rx_done !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_new got d=%h nr=%b rd=%b want c5/1/1", data, new_rx, rx_done);
    end
    instruction = 2'b00; slave_valid = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    instruction = 2'b11; burst_num = 12'd0;
    tick();
    slave_valid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      rx_data = 1'b1;
      tick();
    end
    slave_valid = 1'b0;
    tick();
    n_checks++;
    if (new_rx !== 1'b0 || master_ready !== 1'b1 || data !== 8'hC5) begin
      n_fail++;
      $display("FAIL abort_drop got nr=%b mr=%b d=%h want 0/1/c5", new_rx, master_ready, data);
    end
    tick();
    n_checks++;
    if (master_ready !== 1'b1 || rx_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_wait got mr=%b rd=%b want 1/0", master_ready, rx_done);
    end
    slave_valid = 1'b1;
    tick();
    send_byte(8'h96, "abort");
    n_checks++;
    if (data !== 8'h96 || new_rx !== 1'b1 || rx_done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_retry got d=%h nr=%b rd=%b want 96/1/1", data, new_rx, rx_done);
    end
    instruction = 2'b00; slave_valid = 1'b0;
    tick();
    n_checks++;
    if (rx_done !== 1'b0 || data !== 8'h96) begin
      n_fail++; $display("FAIL abort_release got rd=%b d=%h want 0/96", rx_done, data);
    end
  endtask

  initial begin
    reset = 1'b1; slave_valid = 1'b0; rx_data = 1'b0;
    burst_num = 12'd0; instruction = 2'b00;
    tick(); tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_single();
    test_release();
    test_burst();
    test_reset_mid_burst();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
